// File: rtl/vreg_pkg.sv
// Shared definitions for the vector register file.
// Default geometry (8 registers x 16 elements x 16 bits), the serial
// sequencer state encoding and the default element type.
package vreg_pkg;

  localparam int NUM_REGS_DEF  = 8;
  localparam int ELEM_W_DEF    = 16;
  localparam int NUM_ELEMS_DEF = 16;

  // Serial sequencer states: idle, or streaming one element per step.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef logic [ELEM_W_DEF-1:0] elem_t;

endpackage

// File: rtl/vreg_elem_seq.sv
// Serial-transfer sequencer for the vector register file.
// Latches direction, register address and length on start, then walks the
// element index from 0 up to len-1. The element array itself lives in the top.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        start a transfer (ignored while running)
//   write_i        direction sampled with start: 1 = write, 0 = read
//   addr_i         register address sampled with start
//   len_i          element count sampled with start; 0 or > NUM_ELEMS = full vector
//   din_valid_i    serial write element valid (write steps advance only on it)
//   idx_o          current element index
//   active_o       transfer in progress
//   dir_o          latched direction (1 = write)
//   addr_o         latched register address
//   last_o         current index is the final one of the transfer
//   state_o        sequencer state, exposed for debug and checkers
module vreg_elem_seq
  import vreg_pkg::*;
#(
  parameter int  NUM_ELEMS = NUM_ELEMS_DEF,
  parameter int  ADDR_W    = 3,
  localparam int IDX_W     = $clog2(NUM_ELEMS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [IDX_W:0]    len_i,
  input  logic              din_valid_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              active_o,
  output logic              dir_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output state_e            state_o
);

  localparam logic [IDX_W:0] FULL_LEN = (IDX_W+1)'(NUM_ELEMS);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W:0]    len_eff;
  logic              step;

  // Out-of-range lengths collapse to a full vector, so the final index is
  // always <= NUM_ELEMS-1 and the index never wraps.
  always_comb begin
    len_eff = len_i;
    if (len_i == '0 || len_i > FULL_LEN) len_eff = FULL_LEN;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    // Reads advance every cycle; writes only when an element is offered.
    step       = (state_q == S_RUN) && (!dir_q || din_valid_i);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          idx_d      = '0;
          dir_d      = write_i;
          addr_d     = addr_i;
          last_idx_d = IDX_W'(len_eff - (IDX_W+1)'(1));
        end
      end
      S_RUN: begin
        if (step) begin
          if (idx_q == last_idx_q) state_d = S_IDLE;
          else                     idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
      dir_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
    end
  end

  assign idx_o    = idx_q;
  assign active_o = (state_q == S_RUN);
  assign dir_o    = dir_q;
  assign addr_o   = addr_q;
  assign last_o   = (idx_q == last_idx_q);
  assign state_o  = state_q;

endmodule

// File: rtl/vector_reg_file.sv
// Vector register file: NUM_REGS vectors of NUM_ELEMS x ELEM_W elements.
// Two registered parallel read ports, one masked parallel write port and a
// serial port that streams one element per cycle.
//
// Ports
//   Clk, Rst                     clock, synchronous active-high reset
//   RdAddrA/DataOutA             read port A (1-cycle latency, write-first)
//   RdAddrB/DataOutB             read port B (1-cycle latency, write-first)
//   WR_p/WrAddr_p/WrMask_p/DataIn_p  masked parallel write
//   S_Start/S_Write/S_Addr/S_Len serial transfer command
//   DataIn_s/DataIn_s_Valid      serial write element
//   DataOut_s/DataOut_s_Valid    serial read element
//   S_Busy                       serial transfer in progress
//   S_Done                       one-cycle pulse with the final element
//
// Serial handshake: a write element is consumed at every edge where
// DataIn_s_Valid is high while busy (no back-pressure); a read element is
// presented for exactly one cycle with DataOut_s_Valid high.
module vector_reg_file
  import vreg_pkg::*;
#(
  parameter int  NUM_REGS  = NUM_REGS_DEF,
  parameter int  ELEM_W    = ELEM_W_DEF,
  parameter int  NUM_ELEMS = NUM_ELEMS_DEF,
  localparam int ADDR_W    = $clog2(NUM_REGS),
  localparam int IDX_W     = $clog2(NUM_ELEMS)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [ADDR_W-1:0]           RdAddrA,
  output logic [NUM_ELEMS*ELEM_W-1:0] DataOutA,
  input  logic [ADDR_W-1:0]           RdAddrB,
  output logic [NUM_ELEMS*ELEM_W-1:0] DataOutB,
  input  logic                        WR_p,
  input  logic [ADDR_W-1:0]           WrAddr_p,
  input  logic [NUM_ELEMS-1:0]        WrMask_p,
  input  logic [NUM_ELEMS*ELEM_W-1:0] DataIn_p,
  input  logic                        S_Start,
  input  logic                        S_Write,
  input  logic [ADDR_W-1:0]           S_Addr,
  input  logic [IDX_W:0]              S_Len,
  input  logic [ELEM_W-1:0]           DataIn_s,
  input  logic                        DataIn_s_Valid,
  output logic [ELEM_W-1:0]           DataOut_s,
  output logic                        DataOut_s_Valid,
  output logic                        S_Busy,
  output logic                        S_Done
);

  logic [ELEM_W-1:0] mem_q [NUM_REGS][NUM_ELEMS];
  logic [ELEM_W-1:0] mem_d [NUM_REGS][NUM_ELEMS];

  logic [NUM_ELEMS*ELEM_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [ELEM_W-1:0]           ser_q, ser_d;
  logic                        ser_valid_q, done_q;

  logic [IDX_W-1:0]  seq_idx;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_active, seq_dir, seq_last;
  state_e            seq_state;
  logic              rd_step, wr_step;

  vreg_elem_seq #(
    .NUM_ELEMS (NUM_ELEMS),
    .ADDR_W    (ADDR_W)
  ) u_seq (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .start_i     (S_Start),
    .write_i     (S_Write),
    .addr_i      (S_Addr),
    .len_i       (S_Len),
    .din_valid_i (DataIn_s_Valid),
    .idx_o       (seq_idx),
    .active_o    (seq_active),
    .dir_o       (seq_dir),
    .addr_o      (seq_addr),
    .last_o      (seq_last),
    .state_o     (seq_state)
  );

  assign rd_step = seq_active && !seq_dir;
  assign wr_step = seq_active && seq_dir && DataIn_s_Valid;

  // Next array contents. The serial write is applied after the parallel
  // write so it wins on a same-element collision.
  always_comb begin
    mem_d = mem_q;
    if (WR_p) begin
      for (int e = 0; e < NUM_ELEMS; e++) begin
        if (WrMask_p[e]) mem_d[WrAddr_p][e] = DataIn_p[ELEM_W*e +: ELEM_W];
      end
    end
    if (wr_step) mem_d[seq_addr][seq_idx] = DataIn_s;
  end

  // All reads look at the next-state array, giving write-first behaviour.
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    for (int e = 0; e < NUM_ELEMS; e++) begin
      rd_a_d[ELEM_W*e +: ELEM_W] = mem_d[RdAddrA][e];
      rd_b_d[ELEM_W*e +: ELEM_W] = mem_d[RdAddrB][e];
    end
    ser_d = mem_d[seq_addr][seq_idx];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_q       <= '{default: '0};
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      ser_q       <= '0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      ser_valid_q <= rd_step;
      if (rd_step) ser_q <= ser_d;
      done_q      <= (rd_step || wr_step) && seq_last;
    end
  end

  assign DataOutA        = rd_a_q;
  assign DataOutB        = rd_b_q;
  assign DataOut_s       = ser_q;
  assign DataOut_s_Valid = ser_valid_q;
  assign S_Busy          = (seq_state == S_RUN);
  assign S_Done          = done_q;

endmodule

// File: tb/tb_vector_reg_file.sv
module tb_vector_reg_file;

  localparam int NR = 8;
  localparam int EW = 16;
  localparam int NE = 16;
  localparam int AW = 3;
  localparam int IW = 4;
  localparam int W  = NE * EW;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] RdAddrA, RdAddrB, WrAddr_p, S_Addr;
  logic [W-1:0]  DataOutA, DataOutB, DataIn_p;
  logic          WR_p, S_Start, S_Write, DataIn_s_Valid;
  logic [NE-1:0] WrMask_p;
  logic [IW:0]   S_Len;
  logic [EW-1:0] DataIn_s, DataOut_s;
  logic          DataOut_s_Valid, S_Busy, S_Done;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vector_reg_file dut (
    .Clk(Clk), .Rst(Rst),
    .RdAddrA(RdAddrA), .DataOutA(DataOutA),
    .RdAddrB(RdAddrB), .DataOutB(DataOutB),
    .WR_p(WR_p), .WrAddr_p(WrAddr_p), .WrMask_p(WrMask_p), .DataIn_p(DataIn_p),
    .S_Start(S_Start), .S_Write(S_Write), .S_Addr(S_Addr), .S_Len(S_Len),
    .DataIn_s(DataIn_s), .DataIn_s_Valid(DataIn_s_Valid),
    .DataOut_s(DataOut_s), .DataOut_s_Valid(DataOut_s_Valid),
    .S_Busy(S_Busy), .S_Done(S_Done)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [EW-1:0] mdl [NR][NE];

  function automatic logic [W-1:0] row(input int r);
    logic [W-1:0] v;
    v = '0;
    for (int e = 0; e < NE; e++) v[EW*e +: EW] = mdl[r][e];
    return v;
  endfunction

  task automatic push_exp(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp_v;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic serial_start(input logic wr, input int addr, input int len);
    S_Start = 1'b1;
    S_Write = wr;
    S_Addr  = AW'(addr);
    S_Len   = (IW+1)'(len);
    tick();
    S_Start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, cyc;
    Rst = 1'b1; RdAddrA = '0; RdAddrB = '0; WR_p = 1'b0; WrAddr_p = '0;
    WrMask_p = '0; DataIn_p = '0; S_Start = 1'b0; S_Write = 1'b0; S_Addr = '0;
    S_Len = '0; DataIn_s = '0; DataIn_s_Valid = 1'b0;
    for (int r = 0; r < NR; r++) for (int e = 0; e < NE; e++) mdl[r][e] = '0;

    // 1. reset
    tick(); tick();
    push_exp('0); check("rst_douta", DataOutA);
    push_exp('0); check("rst_doutb", DataOutB);
    push_exp('0); check("rst_douts", W'(DataOut_s));
    push_exp('0); check("rst_svalid", W'(DataOut_s_Valid));
    push_exp('0); check("rst_busy", W'(S_Busy));
    push_exp('0); check("rst_done", W'(S_Done));
    Rst = 1'b0;
    for (int r = 0; r < NR; r++) begin
      RdAddrA = AW'(r); RdAddrB = AW'(NR - 1 - r);
      push_exp(row(r)); push_exp(row(NR - 1 - r));
      tick();
      check("rst_rd_a", DataOutA);
      check("rst_rd_b", DataOutB);
    end

    // 2. masked parallel write, observed through port A the next cycle
    WR_p = 1'b1; WrAddr_p = 3'd2; WrMask_p = 16'h00FF;
    for (int e = 0; e < NE; e++) DataIn_p[EW*e +: EW] = 16'hBEEF;
    RdAddrA = 3'd2;
    for (int e = 0; e < 8; e++) mdl[2][e] = 16'hBEEF;
    push_exp({{8{16'h0000}}, {8{16'hBEEF}}});
    tick();
    WR_p = 1'b0;
    check("pw_masked", DataOutA);

    // 3. serial write, len 0 = full vector, valid gaps every 3rd cycle
    serial_start(1'b1, 0, 0);
    push_exp(W'(1)); check("sw_busy", W'(S_Busy));
    k = 0; cyc = 0;
    while (k < NE && cyc < 100) begin
      cyc++;
      if (cyc % 3 == 0) begin
        DataIn_s_Valid = 1'b0;
      end else begin
        DataIn_s_Valid = 1'b1;
        DataIn_s = 16'(16'hA000 + k);
      end
      push_exp(W'(DataIn_s_Valid && k == NE - 1));
      tick();
      check("sw_done", W'(S_Done));
      if (DataIn_s_Valid) begin
        mdl[0][k] = DataIn_s;
        k++;
      end
    end
    DataIn_s_Valid = 1'b0;
    push_exp(W'(NE)); check("sw_count", W'(k));
    push_exp(W'(0)); check("sw_busy_end", W'(S_Busy));
    RdAddrA = 3'd0;
    push_exp(row(0)); push_exp(W'(0));
    tick();
    check("sw_readback", DataOutA);
    check("sw_done_pulse", W'(S_Done));

    // 4. serial read, len 5, with an S_Start while busy
    serial_start(1'b0, 0, 5);
    for (int j = 0; j < 5; j++) begin
      if (j == 2) begin S_Start = 1'b1; S_Write = 1'b1; S_Addr = 3'd5; end
      push_exp(W'(1)); push_exp(W'(16'hA000 + j));
      push_exp(W'(j == 4)); push_exp(W'(j != 4));
      tick();
      S_Start = 1'b0;
      check("sr_valid", W'(DataOut_s_Valid));
      check("sr_data", W'(DataOut_s));
      check("sr_done", W'(S_Done));
      check("sr_busy", W'(S_Busy));
    end
    push_exp(W'(0)); push_exp(W'(0));
    tick();
    check("sr_valid_end", W'(DataOut_s_Valid));
    check("sr_busy_ignored_start", W'(S_Busy));

    // len beyond NUM_ELEMS reads the whole vector
    serial_start(1'b0, 0, 31);
    for (int j = 0; j < NE; j++) begin
      push_exp(W'(mdl[0][j])); push_exp(W'(j == NE - 1));
      tick();
      check("srl_data", W'(DataOut_s));
      check("srl_done", W'(S_Done));
    end
    push_exp(W'(0)); tick(); check("srl_valid_end", W'(DataOut_s_Valid));

    // len 1: single element, done with it
    serial_start(1'b0, 2, 1);
    push_exp(W'(16'hBEEF)); push_exp(W'(1)); push_exp(W'(0));
    tick();
    check("sr1_data", W'(DataOut_s));
    check("sr1_done", W'(S_Done));
    check("sr1_busy", W'(S_Busy));

    // 5a. parallel write while reading the same register
    RdAddrA = 3'd3; RdAddrB = 3'd3;
    push_exp(row(3)); tick(); check("byp_old", DataOutA);
    WR_p = 1'b1; WrAddr_p = 3'd3; WrMask_p = '1;
    for (int e = 0; e < NE; e++) begin
      DataIn_p[EW*e +: EW] = 16'($urandom_range(0, 65535));
      mdl[3][e] = DataIn_p[EW*e +: EW];
    end
    push_exp(row(3)); push_exp(row(3));
    tick();
    WR_p = 1'b0;
    check("byp_new_a", DataOutA);
    check("byp_new_b", DataOutB);

    // 5b. serial and parallel write to the same element in one cycle
    serial_start(1'b1, 4, 2);
    WR_p = 1'b1; WrAddr_p = 3'd4; WrMask_p = 16'h0003;
    for (int e = 0; e < NE; e++) DataIn_p[EW*e +: EW] = 16'(16'h1111 * (e + 1));
    DataIn_s_Valid = 1'b1; DataIn_s = 16'h5A5A; RdAddrA = 3'd4;
    mdl[4][0] = 16'h5A5A; mdl[4][1] = 16'h2222;
    push_exp(row(4));
    tick();
    WR_p = 1'b0;
    check("coll_serial_wins", DataOutA);
    DataIn_s = 16'h7777; mdl[4][1] = 16'h7777;
    push_exp(W'(1)); push_exp(row(4));
    tick();
    DataIn_s_Valid = 1'b0;
    check("coll_done", W'(S_Done));
    check("coll_second", DataOutA);

    // 6. reset in the middle of a serial write
    serial_start(1'b1, 6, 8);
    for (int j = 0; j < 4; j++) begin
      DataIn_s_Valid = 1'b1; DataIn_s = 16'(16'hC000 + j);
      tick();
    end
    DataIn_s_Valid = 1'b0;
    Rst = 1'b1;
    for (int r = 0; r < NR; r++) for (int e = 0; e < NE; e++) mdl[r][e] = '0;
    push_exp(W'(0)); push_exp(W'(0)); push_exp(W'(0));
    tick();
    check("mid_rst_busy", W'(S_Busy));
    check("mid_rst_done", W'(S_Done));
    check("mid_rst_valid", W'(DataOut_s_Valid));
    Rst = 1'b0;
    push_exp(W'(0)); tick(); check("mid_rst_no_done", W'(S_Done));
    for (int r = 0; r < NR; r++) begin
      RdAddrA = AW'(r); RdAddrB = AW'(r);
      push_exp(row(r)); push_exp(row(r));
      tick();
      check("mid_rst_rd_a", DataOutA);
      check("mid_rst_rd_b", DataOutB);
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover: observed %0d entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
